// File: rtl/pool_window_gen_if.sv
// Pixel-in / 2x2-window-out bundle between a feature-map source, the window generator
// and the max-pooling stage.
interface pool_window_gen_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] out1;
    logic [DATA_WIDTH-1:0] out2;
    logic [DATA_WIDTH-1:0] out3;
    logic [DATA_WIDTH-1:0] out4;
    logic                  valid_out;
    logic                  frame_done;

    // Source side: streams pixels, observes windows.
    modport master (
        output valid_in,
        output data_in,
        input  out1,
        input  out2,
        input  out3,
        input  out4,
        input  valid_out,
        input  frame_done
    );

    // Window generator side.
    modport slave (
        input  valid_in,
        input  data_in,
        output out1,
        output out2,
        output out3,
        output out4,
        output valid_out,
        output frame_done
    );
endinterface

// File: rtl/pool_window_gen.sv
// Turns a raster-order pixel stream into non-overlapping 2x2 stride-2 windows for the
// max-pooling stage; one instance per channel.
module pool_window_gen #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH  = 224,  // even, >= 2
    parameter int unsigned IMG_HEIGHT = 224   // even, >= 2
) (
    input  logic             clk,
    input  logic             resetn,
    pool_window_gen_if.slave bus
);
    localparam int unsigned COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]      col_q, col_d, col_even;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  col_last, row_last;
    logic                  trigger;
    logic [DATA_WIDTH-1:0] pend_q;
    logic [DATA_WIDTH-1:0] lb_left, lb_right;
    logic [DATA_WIDTH-1:0] out1_q, out2_q, out3_q, out4_q;
    logic                  valid_q, frame_done_q;

    // Holds the even row of the current row pair; never reset.
    logic [DATA_WIDTH-1:0] lb [IMG_WIDTH];

    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign trigger  = bus.valid_in & row_q[0] & col_q[0];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (bus.valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Trigger fires only on odd columns, so the left neighbour is col with bit 0 cleared.
    always_comb begin
        col_even    = col_q;
        col_even[0] = 1'b0;
    end

    assign lb_left  = lb[col_even];
    assign lb_right = lb[col_q];

    always_ff @(posedge clk) begin
        if (bus.valid_in && !row_q[0]) begin
            lb[col_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q        <= '0;
            row_q        <= '0;
            pend_q       <= '0;
            out1_q       <= '0;
            out2_q       <= '0;
            out3_q       <= '0;
            out4_q       <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.valid_in && row_q[0] && !col_q[0]) begin
                pend_q <= bus.data_in;
            end
            if (trigger) begin
                out1_q       <= lb_left;
                out2_q       <= lb_right;
                out3_q       <= pend_q;
                out4_q       <= bus.data_in;
                valid_q      <= 1'b1;
                frame_done_q <= row_last & col_last;
            end
        end
    end

    assign bus.out1       = out1_q;
    assign bus.out2       = out2_q;
    assign bus.out3       = out3_q;
    assign bus.out4       = out4_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: 4x4 frames with hand-known windows plus one
// full 224x224 frame checked against a frame-buffer model.
module tb_pool_window_gen;
    localparam int unsigned DW = 32;
    localparam int BW = 224;
    localparam int BH = 224;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_s, rstn_l;

    pool_window_gen_if #(.DATA_WIDTH(DW)) if_s ();
    pool_window_gen_if #(.DATA_WIDTH(DW)) if_l ();

    pool_window_gen #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4)
    ) u_small (
        .clk   (clk),
        .resetn(rstn_s),
        .bus   (if_s.slave)
    );

    pool_window_gen #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (BW),
        .IMG_HEIGHT(BH)
    ) u_large (
        .clk   (clk),
        .resetn(rstn_l),
        .bus   (if_l.slave)
    );

    typedef struct packed {
        logic [31:0] o1;
        logic [31:0] o2;
        logic [31:0] o3;
        logic [31:0] o4;
        logic        fd;
        logic [31:0] stamp;
    } win_t;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   hold_bad = 0;
    int   fd_stray = 0;
    int   big_fd = 0;
    win_t win_q[$];
    win_t big_q[$];
    logic [127:0] last_s = '0;

    // Pixel indices of each 4x4 window: top-left, top-right, bottom-left, bottom-right.
    int WIN_IDX [4][4] = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};
    int SG_VALS [8] = '{-1, -2, -3, -4, 5, -6, 7, -8};

    int          acc [64];
    logic [31:0] px_a [16];
    logic [31:0] px_b [16];
    logic [31:0] px_sg [16];
    logic [31:0] px_fa [16];
    logic [31:0] px_fr [16];
    logic [31:0] img [BW*BH];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn_s) begin
            last_s <= '0;
        end else if (if_s.valid_out) begin
            win_q.push_back('{o1: if_s.out1, o2: if_s.out2, o3: if_s.out3, o4: if_s.out4,
                              fd: if_s.frame_done, stamp: cyc});
            last_s <= {if_s.out1, if_s.out2, if_s.out3, if_s.out4};
        end else begin
            if ({if_s.out1, if_s.out2, if_s.out3, if_s.out4} !== last_s) hold_bad <= hold_bad + 1;
            if (if_s.frame_done) fd_stray <= fd_stray + 1;
        end
        if (rstn_l && if_l.valid_out) begin
            big_q.push_back('{o1: if_l.out1, o2: if_l.out2, o3: if_l.out3, o4: if_l.out4,
                              fd: if_l.frame_done, stamp: cyc});
            if (if_l.frame_done) big_fd <= big_fd + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_s(input int n);
        repeat (n) begin
            @(negedge clk);
            if_s.valid_in = 1'b0;
        end
    endtask

    task automatic send_s(input logic [31:0] d, output int acc_edge);
        @(negedge clk);
        if_s.valid_in = 1'b1;
        if_s.data_in  = d;
        acc_edge      = cyc + 1;
    endtask

    task automatic stream_s(input logic [31:0] px [16], input int abase, input int first,
                            input int count, input bit gappy);
        int g;
        int e;
        for (int i = first; i < first + count; i++) begin
            g = 0;
            if (gappy && i > 0) g = (i <= 2) ? 1 : int'($urandom_range(0, 3));
            idle_s(g);
            send_s(px[i], e);
            acc[abase+i] = e;
        end
    endtask

    task automatic check_frame_s(input logic [31:0] px [16], input int wbase, input int abase,
                                 input string tag);
        win_t w;
        for (int k = 0; k < 4; k++) begin
            if (wbase + k < win_q.size()) begin
                w = win_q[wbase+k];
                check_eq($sformatf("%s w%0d out1", tag, k), w.o1, px[WIN_IDX[k][0]]);
                check_eq($sformatf("%s w%0d out2", tag, k), w.o2, px[WIN_IDX[k][1]]);
                check_eq($sformatf("%s w%0d out3", tag, k), w.o3, px[WIN_IDX[k][2]]);
                check_eq($sformatf("%s w%0d out4", tag, k), w.o4, px[WIN_IDX[k][3]]);
                check_eq($sformatf("%s w%0d frame_done", tag, k), w.fd, (k == 3));
                check_eq($sformatf("%s w%0d latency", tag, k), w.stamp,
                         acc[abase+WIN_IDX[k][3]]);
            end else begin
                check_eq($sformatf("%s w%0d present", tag, k), win_q.size(), wbase + k + 1);
            end
        end
    endtask

    task automatic check_outs_zero_s(input string tag);
        check_eq({tag, " out1"}, if_s.out1, 0);
        check_eq({tag, " out2"}, if_s.out2, 0);
        check_eq({tag, " out3"}, if_s.out3, 0);
        check_eq({tag, " out4"}, if_s.out4, 0);
        check_eq({tag, " valid_out"}, if_s.valid_out, 0);
        check_eq({tag, " frame_done"}, if_s.frame_done, 0);
    endtask

    initial begin
        int wb;
        int hb;
        int r;
        int c;
        win_t w;

        for (int i = 0; i < 16; i++) begin
            px_a[i]  = i;
            px_b[i]  = 100 + i;
            px_fa[i] = 50 + i;
            px_fr[i] = 20 + i;
            px_sg[i] = (i < 8) ? SG_VALS[i] : 9 + i;
        end

        if_s.valid_in = 1'b0;
        if_s.data_in  = '0;
        if_l.valid_in = 1'b0;
        if_l.data_in  = '0;
        rstn_s = 1'b0;
        rstn_l = 1'b0;
        repeat (3) @(negedge clk);
        check_outs_zero_s("reset");
        rstn_s = 1'b1;
        rstn_l = 1'b1;

        // Basic frame at full rate.
        wb = win_q.size();
        stream_s(px_a, 0, 0, 16, 1'b0);
        idle_s(3);
        check_eq("t1 window count", win_q.size() - wb, 4);
        check_frame_s(px_a, wb, 0, "t1");

        // Same frame with stalls.
        wb = win_q.size();
        hb = hold_bad;
        stream_s(px_a, 16, 0, 16, 1'b1);
        idle_s(3);
        check_eq("t2 window count", win_q.size() - wb, 4);
        check_frame_s(px_a, wb, 16, "t2");
        check_eq("t2 hold between pulses", hold_bad - hb, 0);

        // Two back-to-back frames.
        wb = win_q.size();
        stream_s(px_a, 32, 0, 16, 1'b0);
        stream_s(px_b, 48, 0, 16, 1'b0);
        idle_s(3);
        check_eq("t3 window count", win_q.size() - wb, 8);
        check_frame_s(px_a, wb, 32, "t3a");
        check_frame_s(px_b, wb + 4, 48, "t3b");

        // Signed data passes bit-exact.
        wb = win_q.size();
        stream_s(px_sg, 0, 0, 16, 1'b0);
        idle_s(3);
        check_eq("t4 window count", win_q.size() - wb, 4);
        check_frame_s(px_sg, wb, 0, "t4");

        // Reset after pixel 6 of frame A, then a fresh frame.
        wb = win_q.size();
        stream_s(px_fa, 0, 0, 7, 1'b0);
        idle_s(1);
        check_eq("t5 frame A window count", win_q.size() - wb, 1);
        rstn_s = 1'b0;
        @(negedge clk);
        check_outs_zero_s("t5 during reset");
        rstn_s = 1'b1;
        wb = win_q.size();
        hb = hold_bad;
        stream_s(px_fr, 16, 0, 16, 1'b0);
        idle_s(3);
        check_eq("t5 window count", win_q.size() - wb, 4);
        check_frame_s(px_fr, wb, 16, "t5");
        check_eq("t5 hold between pulses", hold_bad - hb, 0);
        check_eq("small stray frame_done", fd_stray, 0);

        // Full-size frame against the frame-buffer model.
        for (int i = 0; i < BW * BH; i++) img[i] = $urandom;
        for (int i = 0; i < BW * BH; i++) begin
            @(negedge clk);
            if_l.valid_in = 1'b1;
            if_l.data_in  = img[i];
        end
        @(negedge clk);
        if_l.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("big window count", big_q.size(), (BW / 2) * (BH / 2));
        for (int k = 0; k < big_q.size() && k < (BW / 2) * (BH / 2); k++) begin
            w = big_q[k];
            r = 2 * (k / (BW / 2));
            c = 2 * (k % (BW / 2));
            check_eq($sformatf("big w%0d out1", k), w.o1, img[r*BW+c]);
            check_eq($sformatf("big w%0d out2", k), w.o2, img[r*BW+c+1]);
            check_eq($sformatf("big w%0d out3", k), w.o3, img[(r+1)*BW+c]);
            check_eq($sformatf("big w%0d out4", k), w.o4, img[(r+1)*BW+c+1]);
            check_eq($sformatf("big w%0d frame_done", k), w.fd,
                     (k == (BW / 2) * (BH / 2) - 1));
        end
        check_eq("big frame_done pulses", big_fd, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Window generator that feeds the 2x2 max-pooling stage (max4input) in the VGG16 pipeline.
- Accepts one feature-map pixel per valid cycle in raster order (row-major, left to right, top to bottom).
- Emits non-overlapping 2x2, stride-2 windows as four parallel words with a one-cycle valid strobe, matching the pooling stage's valid_in/in1..in4 interface.
- One instance per channel.

Parameters:
- DATA_WIDTH, 32, pixel word width (two's-complement; passed through unmodified).
- IMG_WIDTH, 224, pixels per row. Must be even and >= 2.
- IMG_HEIGHT, 224, rows per frame. Must be even and >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- valid_in  input  1  data_in carries a pixel this cycle.
- data_in  input  DATA_WIDTH  pixel value.
- out1  output  DATA_WIDTH  window top-left (row r, col c).
- out2  output  DATA_WIDTH  window top-right (row r, col c+1).
- out3  output  DATA_WIDTH  window bottom-left (row r+1, col c).
- out4  output  DATA_WIDTH  window bottom-right (row r+1, col c+1).
- valid_out  output  1  out1..out4 hold a complete window this cycle.
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
Interface and reset:
- One clock; reset is asynchronous and active-low (clk, resetn).
- On reset: out1..out4 = 0, valid_out = 0, frame_done = 0, column counter = 0, row counter = 0, pending-pixel register = 0.
- Line-buffer contents are don't-care after reset and are not cleared.
- Reset asserted mid-frame aborts the frame. The next accepted pixel is treated as (row 0, col 0).

Counters:
- col counts 0..IMG_WIDTH-1; row counts 0..IMG_HEIGHT-1.
- Both advance only on cycles with valid_in=1.
- col wraps to 0 after IMG_WIDTH-1 and increments row at the same time.
- row wraps to 0 after IMG_HEIGHT-1, so back-to-back frames need no idle cycles.

Storage:
- Line buffer of IMG_WIDTH words. On even rows (row[0]=0), each accepted pixel is written to line buffer[col].
- Pending register: on odd rows with even col, the accepted pixel is stored in it.
- Odd rows never write the line buffer.

Window emission:
- Trigger: an accepted pixel on an odd row and odd col.
- On the next rising edge, register out1 = lb[col-1], out2 = lb[col], out3 = pending, out4 = data_in, and set valid_out=1.
- Latency: valid_out is high exactly 1 cycle after the triggering pixel is accepted.
- valid_out is a single-cycle pulse per window. Consecutive windows may assert valid_out on consecutive-but-one cycles at full input rate.
- When valid_out=0, out1..out4 hold their last values; they are not zeroed.
- frame_done=1 together with valid_out only for the window triggered by (row IMG_HEIGHT-1, col IMG_WIDTH-1); otherwise 0.

Throughput and counts:
- Input may stall (valid_in=0) for any number of cycles at any position. Stalls never produce a window and never advance state.
- No backpressure: the downstream pooling stage always accepts.
- Windows per frame = (IMG_WIDTH/2) * (IMG_HEIGHT/2).

Buffer access:
- Line-buffer reads of col-1 and col occur in the trigger cycle.
- lb[col] is never written in the same cycle it is read, because reads happen only on odd rows. No read-during-write hazard exists.
- Line-buffer reads may be implemented as two registered reads issued one pixel early, provided the 1-cycle output latency is preserved.

Test Plan:
- Basic 4x4 frame (IMG_WIDTH=4, IMG_HEIGHT=4), data 0..15 streamed with valid_in held high -> exactly four valid_out pulses: (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15). Each pulse occurs 1 cycle after pixels 5, 7, 13 and 15 respectively; frame_done only with (10,11,14,15).
- Same 4x4 frame with valid_in toggled 1,0,1,0 and then random gaps -> identical window values; each valid_out exactly 1 cycle after its trigger pixel; no valid_out during gaps; outputs hold between pulses.
- Two back-to-back 4x4 frames, the second carrying 100..115 -> eight windows; the fifth is (100,101,104,105); two frame_done pulses.
- Signed data: row 0 = -1,-2,-3,-4 and row 1 = 5,-6,7,-8 (32-bit two's complement) -> windows (-1,-2,5,-6) and (-3,-4,7,-8) bit-exact.
- Reset mid-frame: assert resetn=0 after pixel 6 of frame A, release, stream a fresh 4x4 frame 20..35 -> all outputs 0 during reset; windows (20,21,24,25) onward; no window mixing frame A data.
- Default parameters 224x224 with random data -> 12544 windows; scoreboard against a reference model; exactly one frame_done.
